// File: rtl/adder8_frame_accum.sv
// Frame accumulator behind the registered 8-bit adder.
// Sums 9-bit adder results per frame and hands totals out via valid/ready.
module adder8_frame_accum #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_sum,
  input  logic             in_carry,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [7:0]       drop_cnt
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic             accept;
  logic             done;
  logic             free;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic             ovf_nxt;

  always_comb begin
    accept  = in_valid && !clear;
    done    = accept && (cnt == CW'(FRAME_LEN - 1));
    free    = !out_valid || out_ready;
    base    = (state == ACCUM) ? acc : '0;
    sum     = {1'b0, base} + {1'b0, ACC_W'({in_carry, in_sum})};
    ovf_nxt = ovf || sum[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (clear) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else if (accept) begin
        if (done) begin
          state <= IDLE;
          acc   <= '0;
          cnt   <= '0;
          ovf   <= 1'b0;
        end else begin
          state <= ACCUM;
          acc   <= sum[ACC_W-1:0];
          cnt   <= cnt + CW'(1);
          ovf   <= ovf_nxt;
        end
      end

      // Overrun keeps the held result; the new total is lost.
      if (done && free) begin
        out_valid <= 1'b1;
        out_acc   <= sum[ACC_W-1:0];
        out_ovf   <= ovf_nxt;
      end else if (done) begin
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
